// File: rtl/channel_pack_pkg.sv
// Shared sizing helpers and keep decoding for the channel stream packer.
// Latency: none (package of constants and pure functions).
// Backpressure: not applicable.
package channel_pack_pkg;

  // Widest tkeep the item counter decodes; narrower keeps are zero-extended.
  localparam int KEEP_MAX = 256;

  function automatic int item_bytes_of(input int item_width);
    return item_width / 8;
  endfunction

  function automatic int item_count_of(input int tdata_width, input int item_width);
    return tdata_width / item_width;
  endfunction

  // Fill counter must represent 0..2N inclusive.
  function automatic int fill_width_of(input int item_count);
    return $clog2(2 * item_count) + 1;
  endfunction

  // Items in a beat = whole groups inside the run of set keep bits starting
  // at bit 0; anything above the first clear bit is ignored.
  function automatic int keep_to_item_count(input logic [KEEP_MAX-1:0] keep,
                                            input int item_bytes);
    int   ones;
    logic run;
    ones = 0;
    run  = 1'b1;
    for (int b = 0; b < KEEP_MAX; b++) begin
      if (run && keep[b]) ones++;
      else run = 1'b0;
    end
    return ones / item_bytes;
  endfunction

endpackage

// File: rtl/item_accumulator.sv
// 2N-item accumulator: inserts a beat's items at the current fill, drains N items from the bottom.
// Latency: one cycle from insert to visibility on head/fill.
// Backpressure: none internally; the caller only inserts when fill_after_drain < N.
module item_accumulator
  import channel_pack_pkg::*;
#(
  parameter int ITEM_WIDTH = 8,
  parameter int ITEM_COUNT = 32,
  parameter int FILL_W     = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ITEM_COUNT*ITEM_WIDTH-1:0] in_items,
  input  logic [FILL_W-1:0]                in_count,
  input  logic                             in_en,
  input  logic                             drain,
  input  logic                             clear,
  output logic [ITEM_COUNT*ITEM_WIDTH-1:0] head,
  output logic [FILL_W-1:0]                fill,
  output logic [FILL_W-1:0]                fill_after_drain
);

  localparam int NW = ITEM_COUNT * ITEM_WIDTH;
  localparam int AW = 2 * NW;

  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_next;
  logic [AW-1:0]     ins;
  logic [FILL_W-1:0] fill_next;

  assign fill_after_drain = drain ? (fill - FILL_W'(ITEM_COUNT)) : fill;
  assign head             = acc[NW-1:0];

  // Next accumulator: optional drain shift, then OR in the masked new items.
  // Bits above fill are kept at zero so flushes emit clean padding.
  always_comb begin
    ins = '0;
    for (int i = 0; i < ITEM_COUNT; i++) begin
      if (i < int'(in_count)) ins[i*ITEM_WIDTH +: ITEM_WIDTH] = in_items[i*ITEM_WIDTH +: ITEM_WIDTH];
    end
    acc_next  = drain ? (acc >> NW) : acc;
    fill_next = fill_after_drain;
    if (in_en) begin
      acc_next  = acc_next | (ins << (int'(fill_after_drain) * ITEM_WIDTH));
      fill_next = fill_after_drain + in_count;
    end
    if (clear) begin
      acc_next  = '0;
      fill_next = '0;
    end
  end

  // Accumulator state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      fill <= '0;
    end else begin
      acc  <= acc_next;
      fill <= fill_next;
    end
  end

endmodule

// File: rtl/channel_stream_packer.sv
// Repacks LSB-aligned partial AXI-Stream beats into dense full beats, flushing a partial beat on tlast.
// Latency: output register loads on the edge after the accept that completes N items or the tlast beat.
// Backpressure: output held while !packed_tready; sparse_tready drops when the accumulator cannot take N more items or a flush is pending.
module channel_stream_packer
  import channel_pack_pkg::*;
#(
  parameter int TDATA_WIDTH = 256,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int TUSER_WIDTH = 128,
  parameter int ITEM_WIDTH  = 8
) (
  input  logic                   axis_aclk,
  input  logic                   axis_reset,
  input  logic [TDATA_WIDTH-1:0] sparse_tdata,
  input  logic [TKEEP_WIDTH-1:0] sparse_tkeep,
  input  logic [TUSER_WIDTH-1:0] sparse_tuser,
  input  logic                   sparse_tvalid,
  output logic                   sparse_tready,
  input  logic                   sparse_tlast,
  output logic [TDATA_WIDTH-1:0] packed_tdata,
  output logic [TKEEP_WIDTH-1:0] packed_tkeep,
  output logic [TUSER_WIDTH-1:0] packed_tuser,
  output logic                   packed_tvalid,
  input  logic                   packed_tready,
  output logic                   packed_tlast
);

  localparam int ITEM_COUNT = item_count_of(TDATA_WIDTH, ITEM_WIDTH);
  localparam int ITEM_BYTES = item_bytes_of(ITEM_WIDTH);
  localparam int FILL_W     = fill_width_of(ITEM_COUNT);

  logic [KEEP_MAX-1:0]    keep_ext;
  logic [FILL_W-1:0]      in_count;
  logic [FILL_W-1:0]      fill;
  logic [FILL_W-1:0]      fill_after_drain;
  logic [TDATA_WIDTH-1:0] head;
  logic [TKEEP_WIDTH-1:0] flush_keep;
  logic [TUSER_WIDTH-1:0] tuser_lat;
  logic                   flush_pending;
  logic                   first_beat;
  logic                   tuser_pend;
  logic                   slot_free;
  logic                   full_load;
  logic                   flush_load;
  logic                   accept;

  // Flush takes priority whenever the remainder fits in one beat, so a packet
  // of exactly k*N items ends with a full tlast beat rather than an empty one.
  assign slot_free  = !packed_tvalid || packed_tready;
  assign full_load  = slot_free && ((fill > FILL_W'(ITEM_COUNT)) ||
                                    ((fill == FILL_W'(ITEM_COUNT)) && !flush_pending));
  assign flush_load = slot_free && flush_pending && (fill <= FILL_W'(ITEM_COUNT));

  assign sparse_tready = !axis_reset && !flush_pending && (fill_after_drain < FILL_W'(ITEM_COUNT));
  assign accept        = sparse_tvalid && sparse_tready;
  assign in_count      = FILL_W'(keep_to_item_count(keep_ext, ITEM_BYTES));

  // Zero-extend tkeep to the decoder width and build the partial flush keep.
  always_comb begin
    keep_ext                  = '0;
    keep_ext[TKEEP_WIDTH-1:0] = sparse_tkeep;
    flush_keep                = '0;
    for (int b = 0; b < TKEEP_WIDTH; b++) begin
      if (b < int'(fill) * ITEM_BYTES) flush_keep[b] = 1'b1;
    end
  end

  item_accumulator #(
    .ITEM_WIDTH (ITEM_WIDTH),
    .ITEM_COUNT (ITEM_COUNT),
    .FILL_W     (FILL_W)
  ) u_acc (
    .clk              (axis_aclk),
    .rst              (axis_reset),
    .in_items         (sparse_tdata),
    .in_count         (in_count),
    .in_en            (accept),
    .drain            (full_load),
    .clear            (flush_load),
    .head             (head),
    .fill             (fill),
    .fill_after_drain (fill_after_drain)
  );

  // Packet framing: pending flush, first-beat detection and tuser capture.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      flush_pending <= 1'b0;
      first_beat    <= 1'b1;
      tuser_pend    <= 1'b0;
      tuser_lat     <= '0;
    end else begin
      if (full_load || flush_load) tuser_pend <= 1'b0;
      if (flush_load) begin
        flush_pending <= 1'b0;
        first_beat    <= 1'b1;
      end
      if (accept) begin
        if (sparse_tlast) flush_pending <= 1'b1;
        if (first_beat) begin
          first_beat <= 1'b0;
          tuser_pend <= 1'b1;
          tuser_lat  <= sparse_tuser;
        end
      end
    end
  end

  // Output register: loads a full or flush beat when the slot is free, holds otherwise.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      packed_tvalid <= 1'b0;
      packed_tdata  <= '0;
      packed_tkeep  <= '0;
      packed_tuser  <= '0;
      packed_tlast  <= 1'b0;
    end else if (slot_free) begin
      if (full_load || flush_load) begin
        packed_tvalid <= 1'b1;
        packed_tdata  <= head;
        packed_tkeep  <= full_load ? {TKEEP_WIDTH{1'b1}} : flush_keep;
        packed_tuser  <= tuser_pend ? tuser_lat : '0;
        packed_tlast  <= flush_load;
      end else begin
        packed_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_channel_stream_packer.sv
// Directed bench for channel_stream_packer with N=32 byte items.
// Latency: checks output ordering and back-to-back timing for dense input.
// Backpressure: exercises a 10-cycle output stall and reset mid-packet.
module tb_channel_stream_packer;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         axis_reset;
  logic [255:0] sparse_tdata;
  logic [31:0]  sparse_tkeep;
  logic [127:0] sparse_tuser;
  logic         sparse_tvalid;
  logic         sparse_tready;
  logic         sparse_tlast;
  logic [255:0] packed_tdata;
  logic [31:0]  packed_tkeep;
  logic [127:0] packed_tuser;
  logic         packed_tvalid;
  logic         packed_tready;
  logic         packed_tlast;

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc   = 0;
  beat_t out_q[$];
  int    out_cyc[$];
  beat_t exp_q[$];

  channel_stream_packer dut (
    .axis_aclk     (clk),
    .axis_reset    (axis_reset),
    .sparse_tdata  (sparse_tdata),
    .sparse_tkeep  (sparse_tkeep),
    .sparse_tuser  (sparse_tuser),
    .sparse_tvalid (sparse_tvalid),
    .sparse_tready (sparse_tready),
    .sparse_tlast  (sparse_tlast),
    .packed_tdata  (packed_tdata),
    .packed_tkeep  (packed_tkeep),
    .packed_tuser  (packed_tuser),
    .packed_tvalid (packed_tvalid),
    .packed_tready (packed_tready),
    .packed_tlast  (packed_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every accepted output beat mid-cycle.
  always @(negedge clk) begin
    if (packed_tvalid && packed_tready) begin
      out_q.push_back('{packed_tdata, packed_tkeep, packed_tuser, packed_tlast});
      out_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] item_val(input int pkt, input int k);
    return 8'(k + pkt * 37);
  endfunction

  function automatic logic [31:0] keep_n(input int cnt);
    logic [31:0] k;
    k = '0;
    for (int i = 0; i < 32; i++) if (i < cnt) k[i] = 1'b1;
    return k;
  endfunction

  // Input beat: cnt items of packet pkt from stream index start, junk above.
  function automatic logic [255:0] in_beat(input int pkt, input int start, input int cnt);
    logic [255:0] d;
    for (int i = 0; i < 32; i++) d[i*8 +: 8] = (i < cnt) ? item_val(pkt, start + i) : 8'hEE;
    return d;
  endfunction

  task automatic exp_push(input int pkt, input int start, input int cnt,
                          input logic [127:0] u, input logic l);
    beat_t b;
    b.d = '0;
    for (int i = 0; i < 32; i++) if (i < cnt) b.d[i*8 +: 8] = item_val(pkt, start + i);
    b.k = keep_n(cnt);
    b.u = u;
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [255:0] d, input logic [31:0] k,
                      input logic [127:0] u, input logic l);
    logic got;
    got           = 1'b0;
    sparse_tdata  = d;
    sparse_tkeep  = k;
    sparse_tuser  = u;
    sparse_tlast  = l;
    sparse_tvalid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = sparse_tready;
      tick();
    end
    sparse_tvalid = 1'b0;
    if (!got) chk("send accept", {255'b0, got}, 256'd1);
  endtask

  task automatic expect_beats(input string tag);
    int t;
    t = 0;
    while (out_q.size() < exp_q.size() && t < 300) begin
      tick();
      t++;
    end
    repeat (4) tick();
    chk({tag, " count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      chk($sformatf("%s b%0d data", tag, i), out_q[i].d, exp_q[i].d);
      chk($sformatf("%s b%0d keep", tag, i), out_q[i].k, exp_q[i].k);
      chk($sformatf("%s b%0d user", tag, i), out_q[i].u, exp_q[i].u);
      chk($sformatf("%s b%0d last", tag, i), out_q[i].l, exp_q[i].l);
    end
    out_q.delete();
    out_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    beat_t snap;
    logic  saw_low;
    int    t;

    axis_reset    = 1'b1;
    sparse_tdata  = '0;
    sparse_tkeep  = '1;
    sparse_tuser  = '0;
    sparse_tlast  = 1'b0;
    sparse_tvalid = 1'b1;
    packed_tready = 1'b1;
    repeat (3) tick();

    // Reset state.
    @(negedge clk);
    chk("rst sparse_tready", sparse_tready, 0);
    chk("rst packed_tvalid", packed_tvalid, 0);
    chk("rst packed_tdata", packed_tdata, 0);
    chk("rst packed_tkeep", packed_tkeep, 0);
    chk("rst packed_tuser", packed_tuser, 0);
    chk("rst packed_tlast", packed_tlast, 0);
    tick();
    sparse_tvalid = 1'b0;
    axis_reset    = 1'b0;
    @(negedge clk);
    chk("idle sparse_tready", sparse_tready, 1);
    chk("idle packed_tvalid", packed_tvalid, 0);
    tick();

    // Dense packet: 3 full beats back to back.
    for (int b = 0; b < 3; b++)
      send(in_beat(1, b * 32, 32), '1, (b == 0) ? 128'hA1 : 128'h0, b == 2);
    t = 0;
    while (out_q.size() < 3 && t < 50) begin tick(); t++; end
    for (int i = 1; i < out_cyc.size(); i++)
      chk($sformatf("dense gap %0d", i), out_cyc[i] - out_cyc[i-1], 1);
    exp_push(1, 0, 32, 128'hA1, 1'b0);
    exp_push(1, 32, 32, 128'h0, 1'b0);
    exp_push(1, 64, 32, 128'h0, 1'b1);
    expect_beats("dense");

    // Sparse packet: 6 beats of 11 items -> 32, 32, 2.
    for (int b = 0; b < 6; b++)
      send(in_beat(2, b * 11, 11), 32'h7FF, (b == 0) ? 128'hB2 : 128'h0, b == 5);
    exp_push(2, 0, 32, 128'hB2, 1'b0);
    exp_push(2, 32, 32, 128'h0, 1'b0);
    exp_push(2, 64, 2, 128'h0, 1'b1);
    expect_beats("sparse");

    // Exact multiple: full beat, then an empty tlast beat.
    send(in_beat(4, 0, 32), '1, 128'hC4, 1'b0);
    send(in_beat(4, 32, 0), 32'h0, 128'h0, 1'b1);
    exp_push(4, 0, 32, 128'hC4, 1'b0);
    exp_push(4, 32, 0, 128'h0, 1'b1);
    expect_beats("exact");

    // Backpressure: stall the output for 10 cycles mid-packet.
    saw_low = 1'b0;
    fork
      begin
        for (int b = 0; b < 4; b++)
          send(in_beat(5, b * 32, 32), '1, (b == 0) ? 128'hD5 : 128'h0, b == 3);
      end
      begin
        repeat (3) tick();
        packed_tready = 1'b0;
        @(negedge clk);
        snap = '{packed_tdata, packed_tkeep, packed_tuser, packed_tlast};
        chk("bp valid at stall", packed_tvalid, 1);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("bp hold valid", packed_tvalid, 1);
          chk("bp hold data", packed_tdata, snap.d);
          chk("bp hold keep", packed_tkeep, snap.k);
          chk("bp hold user", packed_tuser, snap.u);
          chk("bp hold last", packed_tlast, snap.l);
          if (!sparse_tready) saw_low = 1'b1;
        end
        tick();
        packed_tready = 1'b1;
      end
    join
    chk("bp sparse_tready fell", saw_low, 1);
    for (int b = 0; b < 4; b++) exp_push(5, b * 32, 32, (b == 0) ? 128'hD5 : 128'h0, b == 3);
    expect_beats("bp");

    // Reset mid-packet with a full beat sitting in the output register.
    packed_tready = 1'b0;
    send(in_beat(6, 0, 20), keep_n(20), 128'hE6, 1'b0);
    send(in_beat(6, 20, 20), keep_n(20), 128'h0, 1'b0);
    repeat (2) tick();
    chk("rst mid valid before", packed_tvalid, 1);
    axis_reset = 1'b1;
    @(negedge clk);
    chk("rst mid sparse_tready", sparse_tready, 0);
    tick();
    axis_reset = 1'b0;
    @(negedge clk);
    chk("rst mid packed_tvalid", packed_tvalid, 0);
    chk("rst mid packed_tdata", packed_tdata, 0);
    chk("rst mid packed_tkeep", packed_tkeep, 0);
    tick();
    packed_tready = 1'b1;
    send(in_beat(7, 0, 5), keep_n(5), 128'hF7, 1'b1);
    exp_push(7, 0, 5, 128'hF7, 1'b1);
    expect_beats("after rst");

    // Zero-item packet.
    send(in_beat(8, 0, 0), 32'h0, 128'h18, 1'b1);
    exp_push(8, 0, 0, 128'h18, 1'b1);
    expect_beats("zero");

    // Non-contiguous keep: only item 0 counts.
    send(in_beat(9, 0, 8), 32'h000000F5, 128'h29, 1'b1);
    exp_push(9, 0, 1, 128'h29, 1'b1);
    expect_beats("noncontig");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
